socket_fifo: RTL
================

// Module: socket_fifo
// PURPOSE
//  Elastic socket buffer between two processing stages: captures data/dv from the upstream stage
//  and releases one word per rd_en to the downstream stage. Exposes full/empty/occupancy to the
//  socket controller, which throttles rd_en. Sits directly upstream of every processing stage input.
// PARAMETERS
//  DATA_WIDTH   8   width of one data word
//  SOCKET_SIZE  4   FIFO depth in words; any value >= 2, not restricted to powers of 2
//  AFULL_LEVEL  3   o_afull asserts when occupancy >= AFULL_LEVEL; legal range 1..SOCKET_SIZE
// PORTS
//  i_clk     in   1                          single clock, rising edge
//  i_rst     in   1                          asynchronous, active-high reset
//  i_data    in   DATA_WIDTH                 write data from the upstream stage
//  i_dv      in   1                          write strobe; one word per cycle
//  i_rd_en   in   1                          read request from the downstream socket controller
//  o_data    out  DATA_WIDTH                 read data; valid when o_dv = 1
//  o_dv      out  1                          read data valid
//  o_full    out  1                          occupancy == SOCKET_SIZE
//  o_afull   out  1                          occupancy >= AFULL_LEVEL
//  o_empty   out  1                          occupancy == 0
//  o_count   out  $clog2(SOCKET_SIZE+1)      current occupancy
//  o_ovf     out  1                          sticky: a write was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers = 0, count = 0, o_dv = 0, o_data = 0,
//    o_empty = 1, o_full = 0, o_afull = 0, o_ovf = 0. Memory contents are not reset.
//  - Occupancy state: EMPTY (count 0), PARTIAL, FULL (count SOCKET_SIZE). State is derived from
//    count, and all flags are registered from count_next (no combinational path from inputs).
//  - Write accepted (wr_ok) = i_dv & (~o_full | rd_ok). Accepted data goes to mem[wptr].
//    wptr wraps from SOCKET_SIZE-1 to 0.
//  - Read accepted (rd_ok) = i_rd_en & ~o_empty.
//    Next cycle: o_data = mem[rptr] (old value), o_dv = 1. rptr wraps like wptr. Read latency = 1 cycle.
//  - i_rd_en while empty: ignored; o_dv = 0 next cycle and o_data holds its last value.
//  - No write-through when empty: a word written in cycle N is readable no earlier than cycle N+1.
//    A read in cycle N+1 gives o_dv = 1 in cycle N+2.
//  - Simultaneous wr_ok & rd_ok: count unchanged. When FULL, the write is accepted because a slot
//    is freed in the same cycle.
//  - i_dv while FULL with no read: word dropped, count unchanged, o_ovf set to 1 until reset.
//  - count_next = count + wr_ok - rd_ok. It never exceeds SOCKET_SIZE and never underflows.
//  - Reset mid-burst: all state clears immediately and o_dv drops asynchronously. In-flight words are lost.
// CONFIGURATION
//  - Macro SOCKET_FIFO_STATS_EN defined: adds outputs o_ovf_cnt[15:0] and o_udf_cnt[15:0].
//    o_ovf_cnt counts dropped writes; o_udf_cnt counts i_rd_en while empty.
//    Both counters saturate at 16'hFFFF and reset to 0.
//  - Macro undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - socket_pkg: ptr_t / cnt_t widths computed from SOCKET_SIZE via $clog2, and the
//    occupancy-state enum {SOCK_EMPTY, SOCK_PARTIAL, SOCK_FULL}.
//  - Sub-module socket_fifo_mem: simple dual-port RAM with synchronous write and registered read.
//    It holds only storage; all pointer, count and flag logic stays in socket_fifo.
// TESTING (DATA_WIDTH=8, SOCKET_SIZE=4, AFULL_LEVEL=3)
//  1. Write 0x11,0x22,0x33,0x44 on consecutive cycles, no reads.
//     -> count 1,2,3,4; o_afull rises at count 3; o_full = 1; o_empty = 0.
//  2. From full, hold i_rd_en 4 cycles.
//     -> o_dv = 1 on the following 4 cycles with data 0x11,0x22,0x33,0x44; ends with o_empty = 1.
//  3. Full, then write 0x55 with no read.
//     -> dropped, o_ovf = 1, count stays 4; subsequent reads return 0x11..0x44 only.
//  4. Full, with i_dv (0x66) and i_rd_en in the same cycle.
//     -> count stays 4, 0x11 is output, 0x66 is read 4th after three more reads (pointer wrap checked).
//  5. Empty, pulse i_rd_en.
//     -> o_dv stays 0; with SOCKET_FIFO_STATS_EN, o_udf_cnt = 1.
//  6. Assert i_rst mid-stream at count 2.
//     -> flags, count and o_dv reach reset values within the same cycle; next write reads back correctly.

Source files
------------

// File: rtl/socket_pkg.sv
// Shared socket FIFO definitions: occupancy-state enum and size-derived width helpers.
// Optional macro SOCKET_FIFO_STATS_EN (used in socket_fifo) adds drop/underflow counters.
package socket_pkg;

  typedef enum logic [1:0] {
    SOCK_EMPTY,
    SOCK_PARTIAL,
    SOCK_FULL
  } sock_state_t;

  function automatic int ptr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic sock_state_t occ_state(input int count, input int size);
    if (count == 0) return SOCK_EMPTY;
    if (count >= size) return SOCK_FULL;
    return SOCK_PARTIAL;
  endfunction

endpackage

// File: rtl/socket_fifo_mem.sv
// Storage-only dual-port RAM for socket_fifo: synchronous write, registered read.
// The read register resets to zero and holds its value when no read is issued.
module socket_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A read and a write to the same slot in one cycle returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/socket_fifo.sv
// Elastic socket buffer between processing stages with registered full/afull/empty flags.
// Define SOCKET_FIFO_STATS_EN to add saturating o_ovf_cnt / o_udf_cnt outputs.
module socket_fifo
  import socket_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SOCKET_SIZE = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_dv,
  input  logic                             i_rd_en,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_dv,
  output logic                             o_full,
  output logic                             o_afull,
  output logic                             o_empty,
  output logic [cnt_w(SOCKET_SIZE)-1:0]    o_count,
`ifdef SOCKET_FIFO_STATS_EN
  output logic                             o_ovf,
  output logic [15:0]                      o_ovf_cnt,
  output logic [15:0]                      o_udf_cnt
`else
  output logic                             o_ovf
`endif
);

  localparam int PTR_W = ptr_w(SOCKET_SIZE);
  localparam int CNT_W = cnt_w(SOCKET_SIZE);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_PTR = ptr_t'(SOCKET_SIZE - 1);

  ptr_t        wptr, rptr;
  cnt_t        count, count_next;
  logic        wr_ok, rd_ok;
  sock_state_t state_next;

  function automatic ptr_t bump(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flags are registered, so acceptance depends only on registered full/empty.
  always_comb begin
    rd_ok      = i_rd_en & ~o_empty;
    wr_ok      = i_dv & (~o_full | rd_ok);
    count_next = count + cnt_t'(wr_ok) - cnt_t'(rd_ok);
    state_next = occ_state(int'(count_next), SOCKET_SIZE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      o_dv    <= 1'b0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
      o_afull <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= bump(wptr);
      if (rd_ok) rptr <= bump(rptr);
      count   <= count_next;
      o_dv    <= rd_ok;
      o_empty <= (state_next == SOCK_EMPTY);
      o_full  <= (state_next == SOCK_FULL);
      o_afull <= (count_next >= cnt_t'(AFULL_LEVEL));
      o_ovf   <= o_ovf | (i_dv & ~wr_ok);
    end
  end

  assign o_count = count;

`ifdef SOCKET_FIFO_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_cnt <= '0;
      o_udf_cnt <= '0;
    end else begin
      if (i_dv && !wr_ok && o_ovf_cnt != 16'hFFFF) o_ovf_cnt <= o_ovf_cnt + 16'd1;
      if (i_rd_en && o_empty && o_udf_cnt != 16'hFFFF) o_udf_cnt <= o_udf_cnt + 16'd1;
    end
  end
`endif

  socket_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SOCKET_SIZE),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_ok),
    .wr_addr (wptr),
    .wr_data (i_data),
    .rd_en   (rd_ok),
    .rd_addr (rptr),
    .rd_data (o_data)
  );

endmodule
